pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined CPU; it generalises the plain 64-bit PC register.
- Holds the fetch PC and advances it by a fixed increment every cycle.
- Supports stall (hold) and branch/jump redirect, and flags misaligned redirect targets.
- Carries the PC and a valid bit down a short history pipeline, so later stages (ID, EX, ...) know the PC of the instruction they hold.
- Sits between the branch-resolution logic and instruction memory.

---
 rtl/pc_unit.sv | 84 ++++++++
 tb/tb_pc_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with redirect, stall and PC history pipeline
// Holds the fetch PC and carries {pc, valid} down a short history pipeline
// so each later stage knows the PC of the instruction it holds.
module pc_unit #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter int               STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [WIDTH-1:0]        redirect_target,
  output logic [WIDTH-1:0]        pc_q,
  output logic [WIDTH-1:0]        pc_next_seq,
  output logic [STAGES*WIDTH-1:0] hist_pc,
  output logic [STAGES-1:0]       hist_valid,
  output logic                    misalign_err
);

  // INC is a power of two, so INC-1 masks exactly the alignment bits.
  // Using a mask keeps INC = 1 legal without a zero-width slice.
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

  logic             fetch_live;
  logic [WIDTH-1:0] target_aligned;
  logic             target_misaligned;
  logic             hist_advance;
  logic [WIDTH-1:0] s1_pc;
  logic             s1_valid;

  // Sequential successor, redirect alignment and the entry for stage 1.
  always_comb begin
    pc_next_seq       = pc_q + INC_W;
    target_aligned    = redirect_target & ~LOW_MASK;
    target_misaligned = |(redirect_target & LOW_MASK);
    // History moves unless a live, non-redirecting cycle is stalled.
    hist_advance      = !fetch_live || redirect || !stall;
    s1_pc             = '0;
    s1_valid          = 1'b0;
    if (fetch_live) begin
      // On redirect the instruction at the old PC is wrong-path: bubble it.
      s1_pc    = pc_q;
      s1_valid = !redirect;
    end
  end

  // Fetch PC, first-cycle hold after reset, and misalign pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VEC;
      fetch_live   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (!fetch_live) begin
        fetch_live <= 1'b1;
      end else if (redirect) begin
        pc_q         <= target_aligned;
        misalign_err <= target_misaligned;
      end else if (!stall) begin
        pc_q <= pc_next_seq;
      end
    end
  end

  // History pipeline: stage k takes stage k-1, stage 1 takes the fetch slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_pc    <= '0;
      hist_valid <= '0;
    end else if (hist_advance) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        hist_pc[k*WIDTH +: WIDTH] <= hist_pc[(k-1)*WIDTH +: WIDTH];
        hist_valid[k]             <= hist_valid[k-1];
      end
      hist_pc[WIDTH-1:0] <= s1_pc;
      hist_valid[0]      <= s1_valid;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit
// A queue-based model of the fetch slot and history is checked against the
// 64-bit instance on every falling edge; literals pin the model and cover
// the 8-bit wrap-around instance.
module tb_pc_unit;

  localparam int STG = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic redirect = 1'b0;
  logic [63:0] redirect_target = '0;

  logic [63:0]      pc_q, pc_next_seq;
  logic [STG*64-1:0] hist_pc;
  logic [STG-1:0]   hist_valid;
  logic             misalign_err;

  logic       w_stall = 1'b0;
  logic       w_redirect = 1'b0;
  logic [7:0] w_target = '0;
  logic [7:0] w_pc, w_next, w_hist_pc;
  logic       w_hist_valid, w_merr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(64), .RESET_VEC(64'h0), .INC(4), .STAGES(STG)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .pc_q(pc_q), .pc_next_seq(pc_next_seq),
    .hist_pc(hist_pc), .hist_valid(hist_valid), .misalign_err(misalign_err)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'hF8), .INC(4), .STAGES(1)) dut_w (
    .clk(clk), .reset(reset), .stall(w_stall), .redirect(w_redirect),
    .redirect_target(w_target), .pc_q(w_pc), .pc_next_seq(w_next),
    .hist_pc(w_hist_pc), .hist_valid(w_hist_valid), .misalign_err(w_merr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: fetch address, a started flag, and a queue of {pc, valid} entries
  // where index 0 is the ID stage.
  logic        m_started = 1'b0;
  logic [63:0] m_pc = '0;
  logic        m_err = 1'b0;
  logic [64:0] m_hist[$];

  task automatic model_reset();
    m_started = 1'b0;
    m_pc = 64'h0;
    m_err = 1'b0;
    m_hist.delete();
    for (int i = 0; i < STG; i++) m_hist.push_back(65'h0);
  endtask

  task automatic model_push(input logic [63:0] p, input logic v);
    m_hist.push_front({p, v});
    void'(m_hist.pop_back());
  endtask

  task automatic model_edge();
    m_err = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
      model_push(64'h0, 1'b0);
    end else if (redirect) begin
      model_push(m_pc, 1'b0);
      m_err = (redirect_target % 4) != 0;
      m_pc  = redirect_target - (redirect_target % 4);
    end else if (!stall) begin
      model_push(m_pc, 1'b1);
      m_pc = m_pc + 64'd4;
    end
  endtask

  // Advance the model on the same events that move the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_edge();
  end

  // Compare the 64-bit instance against the model on every falling edge.
  always @(negedge clk) begin
    logic [STG*64-1:0] e_hpc;
    logic [STG-1:0]    e_hv;
    for (int k = 0; k < STG; k++) begin
      e_hpc[k*64 +: 64] = m_hist[k][64:1];
      e_hv[k]           = m_hist[k][0];
    end
    chk("model_pc_q", 128'(pc_q), 128'(m_pc));
    chk("model_pc_next_seq", 128'(pc_next_seq), 128'(m_pc + 64'd4));
    chk("model_hist_pc", 128'(hist_pc), 128'(e_hpc));
    chk("model_hist_valid", 128'(hist_valid), 128'(e_hv));
    chk("model_misalign_err", 128'(misalign_err), 128'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held for two edges.
    tick(); tick();
    chk("rst_pc_q", 128'(pc_q), 128'h0);
    chk("rst_hist_valid", 128'(hist_valid), 128'h0);
    chk("rst_hist_pc", 128'(hist_pc), 128'h0);
    chk("rst_misalign", 128'(misalign_err), 128'h0);
    chk("rst_w_pc", 128'(w_pc), 128'hF8);
    reset = 1'b0;

    // First edge: fetch goes live, PC holds.
    tick();
    chk("live_pc_hold", 128'(pc_q), 128'h0);
    chk("live_hist_valid", 128'(hist_valid), 128'h0);
    chk("w_pc_hold", 128'(w_pc), 128'hF8);
    chk("w_next_f8", 128'(w_next), 128'hFC);
    tick();
    chk("run_pc_4", 128'(pc_q), 128'h4);
    chk("run_hv_01", 128'(hist_valid), 128'h1);
    chk("run_s1_pc_0", 128'(hist_pc[63:0]), 128'h0);
    chk("w_pc_fc", 128'(w_pc), 128'hFC);
    tick();
    chk("run_pc_8", 128'(pc_q), 128'h8);
    chk("run_hv_11", 128'(hist_valid), 128'h3);
    chk("run_s1_pc_4", 128'(hist_pc[63:0]), 128'h4);
    chk("w_pc_wrap_00", 128'(w_pc), 128'h00);
    chk("w_next_04", 128'(w_next), 128'h04);

    // Stall three edges at pc_q = 8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc_8", 128'(pc_q), 128'h8);
      chk("stall_hist_pc", 128'(hist_pc), {64'h0, 64'h0, 64'h0, 64'h4});
      chk("stall_hv", 128'(hist_valid), 128'h3);
    end
    stall = 1'b0;
    tick();
    chk("after_stall_pc_12", 128'(pc_q), 128'hC);

    // Redirect wins over stall.
    stall = 1'b1; redirect = 1'b1; redirect_target = 64'h100;
    tick();
    chk("redir_pc_100", 128'(pc_q), 128'h100);
    chk("redir_hv_10", 128'(hist_valid), 128'h2);
    chk("redir_s2_pc_8", 128'(hist_pc[127:64]), 128'h8);
    chk("redir_s1_pc_c", 128'(hist_pc[63:0]), 128'hC);
    chk("redir_merr_0", 128'(misalign_err), 128'h0);

    // Misaligned redirect: aligned down, one-cycle error pulse.
    stall = 1'b0; redirect_target = 64'h106;
    tick();
    chk("mis_pc_104", 128'(pc_q), 128'h104);
    chk("mis_merr_1", 128'(misalign_err), 128'h1);
    redirect = 1'b0;
    tick();
    chk("mis_merr_clear", 128'(misalign_err), 128'h0);
    chk("mis_pc_108", 128'(pc_q), 128'h108);

    // Back-to-back redirects: to the current PC, then to the reset vector.
    redirect = 1'b1; redirect_target = 64'h108;
    tick();
    chk("b2b_pc_108", 128'(pc_q), 128'h108);
    redirect_target = 64'h0;
    tick();
    chk("b2b_pc_0", 128'(pc_q), 128'h0);
    chk("b2b_hv_00", 128'(hist_valid), 128'h0);
    redirect = 1'b0;

    // Run up to 0x20, then reset between edges.
    for (int i = 0; i < 8; i++) tick();
    chk("run_pc_20", 128'(pc_q), 128'h20);
    #1 reset = 1'b1;
    #1;
    chk("async_pc", 128'(pc_q), 128'h0);
    chk("async_hv", 128'(hist_valid), 128'h0);
    chk("async_w_pc", 128'(w_pc), 128'hF8);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rerun_pc_8", 128'(pc_q), 128'h8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
